mii_frame_checker: RTL and testbench
====================================

# mii_frame_checker

Frame checker on the 64-bit MII-style word stream produced by the frame generator; sits directly downstream of it and consumes its data/control words each clock. It validates frame framing (start, data, end-of-frame), data-cycle length, and optionally the payload pattern. Per-frame results go out as registered pulses, and good/bad frames are counted for the testbench scoreboard.

## Interface
- DATA_WIDTH, 64: data word width (8 byte lanes, byte0 = bits [7:0])
- CTRL_WIDTH, 8: control word width
- IDLE_CODE, 8'h07: idle character
- START_CODE, 8'hFB: start character, byte0 of a start word
- EOF_CODE, 8'hFD: terminate character, byte7 (bits [63:56]) of an EOF word
- DATA_PATTERN, 8'hAA: expected payload byte
- MIN_CYCLES, 5: minimum data cycles per frame (40 bytes)
- MAX_CYCLES, 17: maximum data cycles per frame (136 bytes)
- COUNT_WIDTH, 16: frame counter width
- clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high
- i_rx_data  in  DATA_WIDTH  incoming word
- i_rx_ctrl  in  CTRL_WIDTH  incoming control flags
- o_frame_done  out  1  one-cycle pulse, frame accepted
- o_frame_error  out  1  one-cycle pulse, error detected
- o_err_code  out  3  error code, valid with o_frame_error
- o_frame_len  out  16  data bytes of the last closed frame (cycles×8)
- o_good_count  out  COUNT_WIDTH  accepted frames, saturating
- o_bad_count  out  COUNT_WIDTH  errors, saturating

## Operation
- Word classification: control word if i_rx_ctrl != 0, else data word. START word = control with byte0 == START_CODE. EOF word = control with byte7 == EOF_CODE. Any other control word is treated as idle.
- Error codes: 0 NONE, 1 SHORT, 2 LONG, 3 PAYLOAD, 4 NO_EOF, 5 RESTART, 6 ORPHAN.
- The FSM has four states:
  - SYNC: reset state. Ignores every word until the first control word. If that word is a START, go to IN_FRAME; otherwise go to WAIT_START.
  - WAIT_START: START goes to IN_FRAME with cycle counter = 0 and payload flag cleared. A data word raises ORPHAN and goes to DRAIN. EOF or idle: stay.
  - IN_FRAME:
    - Data word: cycle counter +1, saturating at 8191. Any byte != DATA_PATTERN sets the sticky payload flag.
    - EOF: close the frame and go to WAIT_START.
    - START: RESTART error, counter and flag reset, stay in IN_FRAME.
    - Idle: NO_EOF error, go to WAIT_START.
  - DRAIN: stays while data words arrive, with no further errors. The first control word exits: START goes to IN_FRAME, anything else goes to WAIT_START.
- Frame close checks, in priority order: count < MIN_CYCLES gives SHORT; count > MAX_CYCLES gives LONG; payload flag set gives PAYLOAD; otherwise the frame is accepted (o_frame_done).
- o_frame_len is updated on every close, accepted or not, and on RESTART/NO_EOF with the partial count×8. It holds otherwise.
- A zero-data frame (START immediately followed by EOF) closes as SHORT with length 0.
- Counters: o_good_count +1 per o_frame_done; o_bad_count +1 per o_frame_error. Both saturate at all-ones and never wrap.
- o_frame_done and o_frame_error are never asserted together.

## Timing
- One input word is sampled per clk. There is no backpressure and no valid strobe.
- All outputs are registered. A result pulse appears in the cycle after the word that caused it is sampled.
- Counters update in the same cycle as their pulse.
- Reset values: o_frame_done 0, o_frame_error 0, o_err_code 0, o_frame_len 0, both counts 0, FSM in SYNC, internal counter 0, payload flag 0.
- Reset asserted mid-frame abandons the frame silently; no error is reported.
- Back-to-back frames (EOF then START in consecutive cycles) are fully supported.

## Configuration
- CHECKER_PAYLOAD_CHECK_EN defined: per-byte DATA_PATTERN compare and the PAYLOAD error are active.
- CHECKER_PAYLOAD_CHECK_EN undefined: the compare logic is absent and the payload flag is tied 0. Code 3 is never produced; all other behaviour is identical.

## Structure
- mii_checker_pkg holds:
  - state_t enum: SYNC, WAIT_START, IN_FRAME, DRAIN
  - err_code_t enum (3-bit codes above)
  - default IDLE/START/EOF code constants
- Sub-module mii_word_decoder (combinational) produces is_ctrl, is_start, is_eof, payload_ok from one word. The checker instantiates it once.

## Test plan
- Reset, one zero word with ctrl 0, idle, START, 5 data words of 0xAA, EOF → no ORPHAN; o_frame_done one cycle after EOF; o_frame_len = 40; good_count = 1.
- Frames with 4 and 18 data cycles → SHORT (len 32) and LONG (len 144); bad_count = 2, good_count unchanged.
- Payload word with byte3 = 8'h55 in a 10-cycle frame → PAYLOAD with macro defined; o_frame_done, len 80 with macro undefined.
- START, 3 data words, START, 6 data words, EOF → RESTART (len 24), then o_frame_done (len 48).
- START, 6 data words, idle word → NO_EOF; data words while in WAIT_START → a single ORPHAN pulse, DRAIN until next START.
- 2^COUNT_WIDTH+2 good frames with COUNT_WIDTH = 4 → good_count stops at 15; i_rst mid-frame → all outputs 0 next cycle.

Source files
------------

// File: rtl/mii_checker_pkg.sv
// mii_checker_pkg: shared types and default character codes for the MII frame checker
package mii_checker_pkg;
  typedef enum logic [1:0] {SYNC, WAIT_START, IN_FRAME, DRAIN} state_t;
  typedef enum logic [2:0] {
    ERR_NONE    = 3'd0,
    ERR_SHORT   = 3'd1,
    ERR_LONG    = 3'd2,
    ERR_PAYLOAD = 3'd3,
    ERR_NO_EOF  = 3'd4,
    ERR_RESTART = 3'd5,
    ERR_ORPHAN  = 3'd6
  } err_code_t;
  localparam logic [7:0] IDLE_CODE_DEF  = 8'h07;
  localparam logic [7:0] START_CODE_DEF = 8'hFB;
  localparam logic [7:0] EOF_CODE_DEF   = 8'hFD;
  localparam logic [7:0] PATTERN_DEF    = 8'hAA;
  localparam int CNT_W = 13;
endpackage

// File: rtl/mii_word_decoder.sv
// mii_word_decoder: classifies one MII word (control/start/EOF) and checks its payload bytes; compare active with CHECKER_PAYLOAD_CHECK_EN
module mii_word_decoder
  import mii_checker_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = 8,
  parameter logic [7:0] IDLE_CODE = IDLE_CODE_DEF,
  parameter logic [7:0] START_CODE = START_CODE_DEF,
  parameter logic [7:0] EOF_CODE = EOF_CODE_DEF,
  parameter logic [7:0] DATA_PATTERN = PATTERN_DEF
) (
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [CTRL_WIDTH-1:0] ctrl_i,
  output logic                  is_ctrl_o,
  output logic                  is_start_o,
  output logic                  is_eof_o,
  output logic                  payload_ok_o
);
  logic unused_ok;
  assign is_ctrl_o  = |ctrl_i;
  assign is_start_o = is_ctrl_o && data_i[7:0] == START_CODE;
  assign is_eof_o   = is_ctrl_o && data_i[DATA_WIDTH-1 -: 8] == EOF_CODE;
  // Idle is simply "any other control word", so its code never needs comparing.
  assign unused_ok  = ^{data_i, IDLE_CODE, DATA_PATTERN};
`ifdef CHECKER_PAYLOAD_CHECK_EN
  // Every byte lane must carry the expected pattern.
  always_comb begin
    payload_ok_o = 1'b1;
    for (int b = 0; b < DATA_WIDTH / 8; b++)
      if (data_i[b*8 +: 8] != DATA_PATTERN) payload_ok_o = 1'b0;
  end
`else
  assign payload_ok_o = 1'b1;
`endif
endmodule

// File: rtl/mii_frame_checker.sv
// mii_frame_checker: validates MII frame framing, length and (with CHECKER_PAYLOAD_CHECK_EN) payload, with per-frame pulses and saturating counters
module mii_frame_checker
  import mii_checker_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = 8,
  parameter logic [7:0] IDLE_CODE = IDLE_CODE_DEF,
  parameter logic [7:0] START_CODE = START_CODE_DEF,
  parameter logic [7:0] EOF_CODE = EOF_CODE_DEF,
  parameter logic [7:0] DATA_PATTERN = PATTERN_DEF,
  parameter int MIN_CYCLES = 5,
  parameter int MAX_CYCLES = 17,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   i_rst,
  input  logic [DATA_WIDTH-1:0]  i_rx_data,
  input  logic [CTRL_WIDTH-1:0]  i_rx_ctrl,
  output logic                   o_frame_done,
  output logic                   o_frame_error,
  output logic [2:0]             o_err_code,
  output logic [15:0]            o_frame_len,
  output logic [COUNT_WIDTH-1:0] o_good_count,
  output logic [COUNT_WIDTH-1:0] o_bad_count
);
  state_t                 state_q, state_d;
  err_code_t              code_q, code_d, close_code;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   flag_q, flag_d, flag_nx;
  logic                   done_q, done_d, err_q, err_d;
  logic [15:0]            len_q, len_d, cur_len;
  logic [COUNT_WIDTH-1:0] good_q, bad_q;
  logic                   is_ctrl, is_start, is_eof, payload_ok;

  mii_word_decoder #(
    .DATA_WIDTH(DATA_WIDTH), .CTRL_WIDTH(CTRL_WIDTH), .IDLE_CODE(IDLE_CODE),
    .START_CODE(START_CODE), .EOF_CODE(EOF_CODE), .DATA_PATTERN(DATA_PATTERN)
  ) u_dec (
    .data_i(i_rx_data), .ctrl_i(i_rx_ctrl), .is_ctrl_o(is_ctrl),
    .is_start_o(is_start), .is_eof_o(is_eof), .payload_ok_o(payload_ok)
  );

`ifdef CHECKER_PAYLOAD_CHECK_EN
  assign flag_nx = flag_q | ~payload_ok;
`else
  logic unused_payload;
  assign unused_payload = payload_ok;
  assign flag_nx = 1'b0;
`endif

  assign cur_len    = {cnt_q, 3'b000};
  assign close_code = cnt_q < CNT_W'(MIN_CYCLES) ? ERR_SHORT :
                      cnt_q > CNT_W'(MAX_CYCLES) ? ERR_LONG :
                      flag_q ? ERR_PAYLOAD : ERR_NONE;

  // Next-state and result decode; START wins over EOF if a word carries both.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    flag_d  = flag_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    code_d  = ERR_NONE;
    len_d   = len_q;
    case (state_q)
      SYNC, DRAIN: if (is_ctrl) begin
        state_d = is_start ? IN_FRAME : WAIT_START;
        cnt_d   = '0;
        flag_d  = 1'b0;
      end
      WAIT_START: begin
        if (is_start) begin
          state_d = IN_FRAME;
          cnt_d   = '0;
          flag_d  = 1'b0;
        end else if (!is_ctrl) begin
          state_d = DRAIN;
          err_d   = 1'b1;
          code_d  = ERR_ORPHAN;
        end
      end
      IN_FRAME: begin
        if (!is_ctrl) begin
          cnt_d  = &cnt_q ? cnt_q : cnt_q + CNT_W'(1);
          flag_d = flag_nx;
        end else if (is_start) begin
          err_d  = 1'b1;
          code_d = ERR_RESTART;
          len_d  = cur_len;
          cnt_d  = '0;
          flag_d = 1'b0;
        end else begin
          state_d = WAIT_START;
          len_d   = cur_len;
          code_d  = is_eof ? close_code : ERR_NO_EOF;
          err_d   = code_d != ERR_NONE;
          done_d  = code_d == ERR_NONE;
        end
      end
      default: state_d = SYNC;
    endcase
  end

  // State, result and saturating counter registers.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= SYNC;
      cnt_q   <= '0;
      flag_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
      len_q   <= '0;
      good_q  <= '0;
      bad_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flag_q  <= flag_d;
      done_q  <= done_d;
      err_q   <= err_d;
      code_q  <= code_d;
      len_q   <= len_d;
      good_q  <= done_d && !(&good_q) ? good_q + COUNT_WIDTH'(1) : good_q;
      bad_q   <= err_d && !(&bad_q) ? bad_q + COUNT_WIDTH'(1) : bad_q;
    end
  end

  assign o_frame_done  = done_q;
  assign o_frame_error = err_q;
  assign o_err_code    = code_q;
  assign o_frame_len   = len_q;
  assign o_good_count  = good_q;
  assign o_bad_count   = bad_q;
endmodule

// File: tb/tb_mii_frame_checker.sv
// tb_mii_frame_checker: randomized frame stimulus with a frame-level reference model and a pulse scoreboard
module tb_mii_frame_checker;
  localparam int CW = 4;
`ifdef CHECKER_PAYLOAD_CHECK_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif
  localparam logic [63:0] DW   = {8{8'hAA}};
  localparam logic [63:0] IDLW = {8{8'h07}};
  localparam logic [63:0] STW  = {{7{8'h07}}, 8'hFB};
  localparam logic [63:0] EOFW = {8'hFD, {7{8'h07}}};

  logic clk = 1'b0, i_rst;
  logic [63:0] i_rx_data;
  logic [7:0] i_rx_ctrl;
  logic o_frame_done, o_frame_error;
  logic [2:0] o_err_code;
  logic [15:0] o_frame_len;
  logic [CW-1:0] o_good_count, o_bad_count;

  typedef struct {
    logic done;
    logic [2:0] code;
    logic [15:0] len;
    logic [CW-1:0] good;
    logic [CW-1:0] bad;
  } exp_t;
  exp_t q[$];
  int errors = 0, checks = 0;
  logic [15:0] m_len;
  logic [CW-1:0] m_good, m_bad;
  bit in_frame;

  mii_frame_checker #(.COUNT_WIDTH(CW)) dut (
    .clk(clk), .i_rst(i_rst), .i_rx_data(i_rx_data), .i_rx_ctrl(i_rx_ctrl),
    .o_frame_done(o_frame_done), .o_frame_error(o_frame_error), .o_err_code(o_err_code),
    .o_frame_len(o_frame_len), .o_good_count(o_good_count), .o_bad_count(o_bad_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic word(input logic [63:0] d, input logic [7:0] c);
    @(posedge clk);
    #1;
    i_rx_data = d;
    i_rx_ctrl = c;
  endtask

  // Frame-level model: each result updates the expected length and saturating counts.
  task automatic expect_result(input logic done, input logic [2:0] code, input logic [15:0] len);
    exp_t e;
    if (done) m_good = &m_good ? m_good : m_good + 1'b1;
    else m_bad = &m_bad ? m_bad : m_bad + 1'b1;
    m_len = len;
    e.done = done; e.code = code; e.len = len; e.good = m_good; e.bad = m_bad;
    q.push_back(e);
  endtask

  // term: 0 = EOF, 1 = START (restart), 2 = idle (missing EOF)
  task automatic frame(input int n, input int bad_i, input int lane, input logic [7:0] v,
                       input int term, input bit need_start);
    logic [63:0] d;
    logic [15:0] len;
    len = 16'(n * 8);
    if (need_start) word(STW, 8'h01);
    for (int i = 0; i < n; i++) begin
      d = DW;
      if (i == bad_i) d[lane*8 +: 8] = v;
      word(d, 8'h00);
    end
    if (term == 1) begin
      word(STW, 8'h01);
      expect_result(1'b0, 3'd5, len);
    end else if (term == 2) begin
      word(IDLW, 8'hFF);
      expect_result(1'b0, 3'd4, len);
    end else begin
      word(EOFW, 8'hFF);
      if (n < 5) expect_result(1'b0, 3'd1, len);
      else if (n > 17) expect_result(1'b0, 3'd2, len);
      else if (PEN && bad_i >= 0 && bad_i < n) expect_result(1'b0, 3'd3, len);
      else expect_result(1'b1, 3'd0, len);
    end
    in_frame = term == 1;
  endtask

  task automatic orphan(input int k);
    for (int i = 0; i < k; i++) begin
      word(DW, 8'h00);
      if (i == 0) expect_result(1'b0, 3'd6, m_len);
    end
    word(IDLW, 8'hFF);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_done"}, 32'(o_frame_done), 0);
    check({tag, "_err"}, 32'(o_frame_error), 0);
    check({tag, "_code"}, 32'(o_err_code), 0);
    check({tag, "_len"}, 32'(o_frame_len), 0);
    check({tag, "_good"}, 32'(o_good_count), 0);
    check({tag, "_bad"}, 32'(o_bad_count), 0);
  endtask

  // Scoreboard monitor: every result pulse must match the oldest expected result.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!i_rst && (o_frame_done || o_frame_error)) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: done=%0b err=%0b code=%0d expected none", o_frame_done, o_frame_error, o_err_code);
        end else begin
          e = q.pop_front();
          check("pulse_done", 32'(o_frame_done), 32'(e.done));
          check("pulse_err", 32'(o_frame_error), 32'(!e.done));
          if (!e.done) check("err_code", 32'(o_err_code), 32'(e.code));
          check("frame_len", 32'(o_frame_len), 32'(e.len));
          check("good_count", 32'(o_good_count), 32'(e.good));
          check("bad_count", 32'(o_bad_count), 32'(e.bad));
        end
      end
    end
  end

  initial begin
    int n, bad_i, lane, term, r;
    logic [7:0] v;
    i_rst = 1'b1;
    i_rx_data = '0;
    i_rx_ctrl = '0;
    m_len = '0; m_good = '0; m_bad = '0; in_frame = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    i_rst = 1'b0;
    word(64'h0, 8'h00);
    word(IDLW, 8'hFF);
    frame(5, -1, 0, 8'h00, 0, 1'b1);
    frame(4, -1, 0, 8'h00, 0, 1'b1);
    frame(18, -1, 0, 8'h00, 0, 1'b1);
    frame(10, 2, 3, 8'h55, 0, 1'b1);
    frame(3, -1, 0, 8'h00, 1, 1'b1);
    frame(6, -1, 0, 8'h00, 0, 1'b0);
    frame(6, -1, 0, 8'h00, 2, 1'b1);
    orphan(3);
    frame(0, -1, 0, 8'h00, 0, 1'b1);
    frame(17, -1, 0, 8'h00, 0, 1'b1);
    for (int it = 0; it < 150; it++) begin
      r = $urandom_range(0, 9);
      if (!in_frame && r == 0) orphan($urandom_range(1, 4));
      else if (!in_frame && r == 1) word(($urandom_range(0, 1) != 0) ? EOFW : IDLW, 8'hFF);
      else begin
        n = $urandom_range(0, 20);
        bad_i = (n > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
        lane = $urandom_range(0, 7);
        v = 8'($urandom_range(0, 255));
        if (v == 8'hAA) v = 8'h55;
        r = $urandom_range(0, 9);
        term = r < 7 ? 0 : r < 9 ? 1 : 2;
        frame(n, bad_i, lane, v, term, !in_frame);
      end
    end
    if (in_frame) frame(8, -1, 0, 8'h00, 0, 1'b0);
    for (int i = 0; i < 18; i++) frame(8, -1, 0, 8'h00, 0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("good_saturated", 32'(o_good_count), 32'(15));
    check("queue_drained", 32'(q.size()), 0);
    word(STW, 8'h01);
    word(DW, 8'h00);
    word(DW, 8'h00);
    @(posedge clk);
    #2;
    i_rst = 1'b1;
    #1;
    check_zero("midreset");
    m_len = '0; m_good = '0; m_bad = '0;
    @(posedge clk);
    #1;
    i_rst = 1'b0;
    word(IDLW, 8'hFF);
    frame(7, -1, 0, 8'h00, 0, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    check("final_queue_drained", 32'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
